// File: rtl/decoder_pkg.sv
// Shared definitions for the registered one-hot decoder family:
// state and mode encodings plus the polarity-aware decode helper.
package decoder_pkg;

    localparam int MAX_W = 8;
    localparam int MAX_N = 1 << MAX_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Full-width decode; callers truncate to their own OUT_N.
    function automatic logic [MAX_N-1:0] onehot_decode(input logic [MAX_W-1:0] idx,
                                                       input logic polarity);
        logic [MAX_N-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return polarity ? ~v : v;
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Divide-by-DIV counter producing a one-cycle step pulse; clr restarts the
// count so the first step lands DIV cycles after the clear.
module scan_prescaler #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic step
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] cnt;

    assign step = run && !clr && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/decoder_scan.sv
// Registered IN_W-to-OUT_N one-hot/one-cold decoder with a direct-load mode
// and a free-running scan mode that steps the index every DIV cycles.
module decoder_scan
    import decoder_pkg::*;
#(
    parameter int IN_W       = 3,
    parameter int OUT_N      = 1 << IN_W,
    parameter int DIV        = 4,
    parameter int ACTIVE_LOW = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic             load,
    input  logic [IN_W-1:0]  in,
    output logic [OUT_N-1:0] out,
    output logic [IN_W-1:0]  idx,
    output logic             wrap,
    output logic             err
);

    localparam logic             POL      = (ACTIVE_LOW != 0);
    localparam logic [OUT_N-1:0] INACTIVE = {OUT_N{POL}};
    localparam logic [IN_W:0]    N_EXT    = (IN_W + 1)'(OUT_N);
    localparam logic [IN_W:0]    LAST_EXT = (IN_W + 1)'(OUT_N - 1);

    state_t          state;
    state_t          state_nx;
    logic            load_ok;
    logic            load_bad;
    logic            pre_clr;
    logic            step;
    logic [IN_W-1:0] idx_nx;
    logic            wrap_nx;

    always_comb begin
        state_nx = ST_IDLE;
        if (en) begin
            state_nx = (mode == MODE_SCAN) ? ST_SCAN : ST_DIRECT;
        end
    end

    assign load_ok  = load && ({1'b0, in} < N_EXT);
    assign load_bad = load && !load_ok;

    // The count only survives while scan continues from one edge to the next;
    // a rejected load freezes it rather than clearing it.
    assign pre_clr = (state != ST_SCAN) || (state_nx != ST_SCAN) || load_ok;

    scan_prescaler #(.DIV(DIV)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (pre_clr),
        .run  (!load_bad),
        .step (step)
    );

    always_comb begin
        idx_nx  = idx;
        wrap_nx = 1'b0;
        if (load_ok) begin
            idx_nx = in;
        end else if (step) begin
            if ({1'b0, idx} == LAST_EXT) begin
                idx_nx  = '0;
                wrap_nx = 1'b1;
            end else begin
                idx_nx = idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            idx   <= '0;
            out   <= INACTIVE;
            wrap  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            wrap  <= wrap_nx;
            err   <= load_bad;
            out   <= (state_nx == ST_IDLE) ? INACTIVE
                                           : OUT_N'(onehot_decode(MAX_W'(idx_nx), POL));
        end
    end

endmodule

// File: tb/tb_decoder_scan.sv
// Bench for decoder_scan: two configurations driven in parallel, a behavioural
// model checked every cycle, plus directed checks with literal expectations.
module tb_decoder_scan;

    logic       clk = 1'b0;
    logic       rst, en, mode, load;
    logic [2:0] in;

    logic [7:0] out0;
    logic [2:0] idx0;
    logic       wrap0, err0;
    logic [4:0] out1;
    logic [2:0] idx1;
    logic       wrap1, err1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    decoder_scan #(.IN_W(3), .OUT_N(8), .DIV(4), .ACTIVE_LOW(0)) u0 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .in(in),
        .out(out0), .idx(idx0), .wrap(wrap0), .err(err0)
    );

    decoder_scan #(.IN_W(3), .OUT_N(5), .DIV(2), .ACTIVE_LOW(1)) u1 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .in(in),
        .out(out1), .idx(idx1), .wrap(wrap1), .err(err1)
    );

    // Model: the index, cycles elapsed since the last scan anchor, and flags.
    int cfg_n[2]  = '{8, 5};
    int cfg_d[2]  = '{4, 2};
    bit cfg_al[2] = '{1'b0, 1'b1};
    int m_idx[2];
    int m_age[2];
    bit m_was_scan[2], m_on[2], m_wrap[2], m_err[2];
    bit armed = 1'b0;
    bit sc, ok, bd;

    function automatic logic [7:0] exp_out(input int i);
        logic [7:0] mask, v;
        mask = 8'((1 << cfg_n[i]) - 1);
        v = m_on[i] ? 8'(1 << m_idx[i]) : 8'h00;
        if (cfg_al[i]) v = ~v & mask;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_idx[i] = 0; m_age[i] = 0; m_was_scan[i] = 0;
                m_on[i] = 0; m_wrap[i] = 0; m_err[i] = 0;
            end else begin
                sc = en && mode;
                bd = load && (int'(in) >= cfg_n[i]);
                ok = load && !bd;
                m_wrap[i] = 0;
                m_err[i]  = bd;
                if (ok) begin
                    m_idx[i] = int'(in);
                    m_age[i] = 0;
                end else if (sc && m_was_scan[i]) begin
                    if (!bd) begin
                        m_age[i]++;
                        if (m_age[i] == cfg_d[i]) begin
                            m_age[i]  = 0;
                            m_wrap[i] = (m_idx[i] == cfg_n[i] - 1);
                            m_idx[i]  = (m_idx[i] + 1) % cfg_n[i];
                        end
                    end
                end else begin
                    m_age[i] = 0;
                end
                m_was_scan[i] = sc;
                m_on[i] = en;
            end
        end
        if (rst) armed = 1'b1;
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("m_out0",  32'(out0),  32'(exp_out(0)));
            chk("m_idx0",  32'(idx0),  32'(m_idx[0]));
            chk("m_wrap0", 32'(wrap0), 32'(m_wrap[0]));
            chk("m_err0",  32'(err0),  32'(m_err[0]));
            chk("m_out1",  32'(out1),  32'(exp_out(1)));
            chk("m_idx1",  32'(idx1),  32'(m_idx[1]));
            chk("m_wrap1", 32'(wrap1), 32'(m_wrap[1]));
            chk("m_err1",  32'(err1),  32'(m_err[1]));
        end
    end

    task automatic cyc(input logic e, input logic m, input logic l, input logic [2:0] i);
        en = e; mode = m; load = l; in = i;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] sweep_tab[8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

    initial begin
        rst = 1'b1;
        cyc(1'b1, 1'b1, 1'b0, 3'd0);
        cyc(1'b1, 1'b1, 1'b0, 3'd0);
        chk("rst_out0", 32'(out0), 32'h00);
        chk("rst_out1", 32'(out1), 32'h1F);
        chk("rst_idx0", 32'(idx0), 32'd0);
        chk("rst_flags", {30'd0, wrap0, err0}, 32'd0);
        rst = 1'b0;

        // Direct sweep, one load per edge.
        for (int k = 0; k < 8; k++) begin
            cyc(1'b1, 1'b0, 1'b1, 3'(k));
            chk("sweep_out0", 32'(out0), 32'(sweep_tab[k]));
        end
        cyc(1'b0, 1'b0, 1'b0, 3'd0);
        chk("idle_out0", 32'(out0), 32'h00);
        chk("idle_idx0", 32'(idx0), 32'd7);
        chk("idle_out1", 32'(out1), 32'h1F);
        chk("idle_idx1", 32'(idx1), 32'd4);

        // Scan from 6 (DIV=4) and, in parallel, from 4 on the five-output unit.
        cyc(1'b1, 1'b0, 1'b1, 3'd6);
        chk("ld6_err1", 32'(err1), 32'd1);
        for (int t = 1; t <= 10; t++) begin
            cyc(1'b1, 1'b1, 1'b0, 3'd0);
            chk("scan_idx0", 32'(idx0), (t < 5) ? 32'd6 : (t < 9) ? 32'd7 : 32'd0);
            chk("scan_wrap0", 32'(wrap0), 32'(t == 9));
            chk("scan_wrap1", 32'(wrap1), 32'(t == 3));
        end

        // Load coinciding with a DIV=2 step edge.
        cyc(1'b1, 1'b0, 1'b0, 3'd0);
        cyc(1'b1, 1'b1, 1'b0, 3'd0);
        cyc(1'b1, 1'b1, 1'b0, 3'd0);
        cyc(1'b1, 1'b1, 1'b1, 3'd3);
        chk("coll_idx1", 32'(idx1), 32'd3);
        chk("coll_wrap1", 32'(wrap1), 32'd0);
        cyc(1'b1, 1'b1, 1'b0, 3'd0);
        chk("coll_hold1", 32'(idx1), 32'd3);
        cyc(1'b1, 1'b1, 1'b0, 3'd0);
        chk("coll_step1", 32'(idx1), 32'd4);

        // Rejected load on the five-output unit.
        cyc(1'b1, 1'b0, 1'b1, 3'd6);
        chk("bad_err1", 32'(err1), 32'd1);
        chk("bad_idx1", 32'(idx1), 32'd4);
        chk("bad_out1", 32'(out1), 32'h0F);
        cyc(1'b1, 1'b0, 1'b0, 3'd0);
        chk("bad_err1_clr", 32'(err1), 32'd0);

        // Mode toggle mid-scan freezes idx; re-entry restarts the DIV count.
        cyc(1'b1, 1'b0, 1'b1, 3'd2);
        cyc(1'b1, 1'b1, 1'b0, 3'd0);
        cyc(1'b1, 1'b1, 1'b0, 3'd0);
        cyc(1'b1, 1'b0, 1'b0, 3'd0);
        chk("tog_frozen0", 32'(idx0), 32'd2);
        for (int j = 1; j <= 5; j++) begin
            cyc(1'b1, 1'b1, 1'b0, 3'd0);
            chk("tog_idx0", 32'(idx0), (j < 5) ? 32'd2 : 32'd3);
        end

        // Random traffic, checked by the per-cycle model compare.
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            cyc($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 7) == 0, 3'($urandom_range(0, 7)));
        end
        rst = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 3'd0);
        @(negedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
